// File: rtl/uart_pkg.sv
// uart_pkg: receive FSM states and line-level constants shared by the UART blocks
package uart_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam logic IDLE_BIT = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT = 1'b1;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD = 1'b1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, CHECK} rx_state_t;
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: bit-period timing (edge/bit counters) and 3-sample majority vote
module uart_rx_sampler #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    input  logic                  idle,
    input  logic                  start,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [BIT_W-1:0]      bit_cnt,
    output logic                  wrap,
    output logic                  dec,
    output logic                  bit_val
);
    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] TWO = PRESCALE_W'(2);
    logic [PRESCALE_W-1:0] p, e_cnt, half;
    logic [1:0] smp;
    assign half = p >> 1;
    assign wrap = !idle && e_cnt == p - ONE;
    assign dec = !idle && e_cnt == half + TWO;
    // the start-detect cycle is edge 0, so the counter leaves idle at 1; vote registered after the third sample
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            p <= '0;
            e_cnt <= '0;
            bit_cnt <= '0;
            smp <= '0;
            bit_val <= 1'b0;
        end else begin
            if (idle && start) p <= prescale;
            e_cnt <= idle ? (start ? ONE : '0) : wrap ? '0 : e_cnt + ONE;
            bit_cnt <= idle ? '0 : bit_cnt + BIT_W'(wrap);
            if (e_cnt == half - ONE) smp[0] <= rx;
            if (e_cnt == half) smp[1] <= rx;
            if (e_cnt == half + ONE) bit_val <= (smp[0] & smp[1]) | (smp[0] & rx) | (smp[1] & rx);
        end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with parity/stop checking; UART_RX_SYNC_EN adds a 2-flop RX_IN synchronizer
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);
    localparam int BIT_W = $clog2(DATA_WIDTH + 3);
    rx_state_t state, nxt;
    logic rx, rx_prev, start_det, idle, wrap, dec, bit_val;
    logic par_en_q, par_typ_q, par_flag, stp_flag, par_exp;
    logic [BIT_W-1:0] bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
`ifdef UART_RX_SYNC_EN
    logic [1:0] sync;
    // two-flop synchronizer, resting at the line's idle level
    always_ff @(posedge CLK or negedge RST)
        if (!RST) sync <= {2{IDLE_BIT}};
        else sync <= {sync[0], RX_IN};
    assign rx = sync[1];
`else
    assign rx = RX_IN;
`endif
    assign idle = state == IDLE;
    assign start_det = rx == START_BIT && rx_prev == IDLE_BIT;
    assign par_exp = (par_typ_q == PAR_ODD) ? ~^shift : ^shift;
    uart_rx_sampler #(.PRESCALE_W(PRESCALE_W), .BIT_W(BIT_W)) u_sampler (
        .clk(CLK),
        .rst_n(RST),
        .rx(rx),
        .idle(idle),
        .start(start_det),
        .prescale(Prescale),
        .bit_cnt(bit_cnt),
        .wrap(wrap),
        .dec(dec),
        .bit_val(bit_val)
    );
    // state register
    always_ff @(posedge CLK or negedge RST)
        if (!RST) state <= IDLE;
        else state <= nxt;
    // next-state: bit_cnt counts bit periods from the start bit, so data ends at DATA_WIDTH
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start_det ? START : IDLE;
            START:   nxt = (dec && bit_val != START_BIT) ? IDLE : wrap ? DATA : START;
            DATA:    nxt = (wrap && bit_cnt == BIT_W'(DATA_WIDTH)) ? (par_en_q ? PARITY : STOP) : DATA;
            PARITY:  nxt = wrap ? STOP : PARITY;
            STOP:    nxt = dec ? CHECK : STOP;
            CHECK:   nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    // frame config capture, deserializer, error flags; P_DATA loads on a clean stop so it is current during CHECK
    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            rx_prev <= 1'b0;
            par_en_q <= 1'b0;
            par_typ_q <= 1'b0;
            par_flag <= 1'b0;
            stp_flag <= 1'b0;
            shift <= '0;
            P_DATA <= '0;
        end else begin
            rx_prev <= rx;
            if (idle && start_det) begin
                par_en_q <= PAR_EN;
                par_typ_q <= PAR_TYP;
                par_flag <= 1'b0;
            end
            if (state == DATA && dec) shift <= {bit_val, shift[DATA_WIDTH-1:1]};
            if (state == PARITY && dec) par_flag <= bit_val != par_exp;
            if (state == STOP && dec) begin
                stp_flag <= bit_val != STOP_BIT;
                if (!par_flag && bit_val == STOP_BIT) P_DATA <= shift;
            end
        end
    // strobes exist only in CHECK, so reset or abort can never leave one asserted
    always_comb begin
        DATA_VALID = state == CHECK && !par_flag && !stp_flag;
        PAR_ERR = state == CHECK && par_flag;
        STP_ERR = state == CHECK && stp_flag;
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: frame-level model of expected strobes/data checked every cycle, plus literal spot checks
module tb_uart_rx;
    logic CLK = 1'b0, RST = 1'b0, RX_IN = 1'b1, PAR_EN = 1'b0, PAR_TYP = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic [7:0] P_DATA;
    logic DATA_VALID, PAR_ERR, STP_ERR;

    uart_rx dut (
        .CLK(CLK),
        .RST(RST),
        .RX_IN(RX_IN),
        .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP),
        .Prescale(Prescale),
        .P_DATA(P_DATA),
        .DATA_VALID(DATA_VALID),
        .PAR_ERR(PAR_ERR),
        .STP_ERR(STP_ERR)
    );

    always #5 CLK = ~CLK;

`ifdef UART_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        int cyc;
        logic dv, pe, se;
        logic [7:0] data;
    } ev_t;

    ev_t q[$];
    int cyc = 0, n_cmp = 0, n_bad = 0;
    int n_dv = 0, n_pe = 0, n_se = 0, last_dv = -1, last_se = -1;
    logic [7:0] m_pdata = 8'h00;
    logic edv, epe, ese;

    always @(posedge CLK) cyc <= cyc + 1;

    // per-cycle comparison against the frame-level expectation queue
    initial forever begin
        @(posedge CLK);
        #1;
        edv = 1'b0;
        epe = 1'b0;
        ese = 1'b0;
        if (!RST) m_pdata = 8'h00;
        if (q.size() > 0 && q[0].cyc < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL strobe_missed: expected event at cycle %0d not seen (now %0d)", q[0].cyc, cyc);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            edv = q[0].dv;
            epe = q[0].pe;
            ese = q[0].se;
            if (q[0].dv) m_pdata = q[0].data;
            void'(q.pop_front());
        end
        n_cmp++;
        if ({DATA_VALID, PAR_ERR, STP_ERR, P_DATA} !== {edv, epe, ese, m_pdata}) begin
            n_bad++;
            $display("FAIL outputs cycle %0d: dv/pe/se/p_data got %b%b%b %h want %b%b%b %h",
                     cyc, DATA_VALID, PAR_ERR, STP_ERR, P_DATA, edv, epe, ese, m_pdata);
        end
        if (DATA_VALID) begin n_dv++; last_dv = cyc; end
        if (PAR_ERR) n_pe++;
        if (STP_ERR) begin n_se++; last_se = cyc; end
    end

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // drive one frame (n_drive>0 stops early); config is perturbed after the start bit to prove it is latched
    task automatic frame(input logic [7:0] d, input int p, input bit pen, input bit ptyp,
                         input bit pbit, input bit stop, input bit glitch, input int n_drive,
                         output int t0);
        logic b [11];
        int nb;
        ev_t ev;
        nb = pen ? 11 : 10;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[i+1] = d[i];
        b[9] = pen ? pbit : stop;
        b[10] = stop;
        ev.pe = pen && (pbit != (^d ^ ptyp));
        ev.se = !stop;
        ev.dv = !ev.pe && !ev.se;
        ev.data = d;
        t0 = 0;
        for (int k = 0; k < nb; k++) begin
            if (n_drive > 0 && k >= n_drive) break;
            for (int e = 0; e < p; e++) begin
                @(negedge CLK);
                if (k == 0 && e == 0) begin
                    t0 = cyc;
                    Prescale = 6'(p);
                    PAR_EN = pen;
                    PAR_TYP = ptyp;
                    ev.cyc = t0 + LAT + (nb - 1) * p + p / 2 + 3;
                    q.push_back(ev);
                end
                if (k == 1 && e == 0) begin
                    Prescale = (p == 16) ? 6'd8 : 6'd16;
                    PAR_EN = !pen;
                    PAR_TYP = !ptyp;
                end
                RX_IN = (glitch && k >= 1 && k <= 8 && e == p / 2) ? !b[k] : b[k];
            end
        end
    endtask

    initial begin
        int t0;
        idle_cycles(3);
        RST = 1'b1;
        idle_cycles(5);

        frame(8'hA5, 8, 0, 0, 0, 1, 0, 0, t0);
        idle_cycles(10);
        check("a5_latency", last_dv - t0, 79 + LAT);
        check("a5_pdata", int'(P_DATA), 'hA5);
        check("a5_dv_count", n_dv, 1);

        frame(8'h3C, 16, 1, 0, 0, 1, 0, 0, t0);
        idle_cycles(20);
        check("3c_latency", last_dv - t0, 171 + LAT);
        check("3c_pdata", int'(P_DATA), 'h3C);

        frame(8'h3C, 16, 1, 0, 1, 1, 0, 0, t0);
        idle_cycles(20);
        check("par_err_count", n_pe, 1);
        check("par_err_pdata_held", int'(P_DATA), 'h3C);
        check("par_err_no_dv", n_dv, 2);

        frame(8'h81, 32, 1, 1, 1, 0, 0, 0, t0);
        RX_IN = 1'b1;
        idle_cycles(40);
        check("stp_latency", last_se - t0, 339 + LAT);
        check("stp_err_count", n_se, 1);
        check("stp_pdata_held", int'(P_DATA), 'h3C);

        Prescale = 6'd16;
        RX_IN = 1'b0;
        idle_cycles(3);
        RX_IN = 1'b1;
        idle_cycles(30);
        frame(8'h55, 16, 0, 0, 0, 1, 0, 0, t0);
        idle_cycles(20);
        check("after_glitch_pdata", int'(P_DATA), 'h55);
        check("after_glitch_dv_count", n_dv, 3);

        frame(8'h0F, 16, 0, 0, 0, 1, 1, 0, t0);
        idle_cycles(20);
        check("vote_pdata", int'(P_DATA), 'h0F);

        frame(8'h00, 8, 0, 0, 0, 0, 0, 0, t0);
        idle_cycles(100);
        RX_IN = 1'b1;
        idle_cycles(20);
        check("break_stp_count", n_se, 2);
        check("break_dv_count", n_dv, 4);

        frame(8'h12, 16, 0, 0, 0, 1, 0, 0, t0);
        frame(8'h34, 16, 0, 0, 0, 1, 0, 0, t0);
        check("b2b_pdata", int'(P_DATA), 'h34);
        check("b2b_dv_count", n_dv, 6);
        frame(8'h56, 16, 0, 0, 0, 1, 0, 4, t0);
        void'(q.pop_back());
        @(negedge CLK);
        #2;
        RST = 1'b0;
        RX_IN = 1'b1;
        #1;
        check("async_rst_pdata", int'(P_DATA), 0);
        check("async_rst_dv", int'(DATA_VALID), 0);
        idle_cycles(3);
        RST = 1'b1;
        idle_cycles(200);
        check("no_third_strobe", n_dv, 6);
        check("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
